// File: rtl/acc_load_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// acc_load_unit_if : source-select / accumulator bus for acc_load_unit  (rev 1.0)
// ---------------------------------------------------------------------------
interface acc_load_unit_if #(
   parameter int len_data = 16,
   parameter int num_src  = 3,
   parameter int len_sel  = 2
) ();
   logic [len_sel-1:0]          SelA;
   logic                        WrAcc;
   logic [num_src*len_data-1:0] src_bus;
   logic [len_data-1:0]         acc;
   logic                        stall;
   logic                        load_done;
   logic                        acc_zero;
   logic                        acc_neg;

   modport master (
      output SelA, WrAcc, src_bus,
      input  acc, stall, load_done, acc_zero, acc_neg
   );

   modport slave (
      input  SelA, WrAcc, src_bus,
      output acc, stall, load_done, acc_zero, acc_neg
   );
endinterface
`default_nettype wire

// File: rtl/acc_load_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// acc_load_unit : accumulator loader with multi-cycle data-memory wait  (rev 1.0)
// ---------------------------------------------------------------------------
module acc_load_unit #(
   parameter int len_data = 16,
   parameter int num_src  = 3,
   parameter int len_sel  = 2,
   parameter int mem_lat  = 2
) (
   input  wire logic        clk,
   input  wire logic        reset,
   acc_load_unit_if.slave   bus
);
   localparam int cnt_w = $clog2(mem_lat + 1);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_MEM = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [cnt_w-1:0]    cnt_q, cnt_d;
   logic [len_data-1:0] acc_q, acc_d;
   logic                stall_q, stall_d;
   logic                load_done_q, load_done_d;
   logic [len_data-1:0] sel_data;

   // Codes at or beyond num_src fall through to zero.
   always_comb begin
      sel_data = '0;
      for (int k = 1; k < num_src; k++) begin
         if (bus.SelA == len_sel'(k)) begin
            sel_data = bus.src_bus[k*len_data +: len_data];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      stall_d     = stall_q;
      load_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.WrAcc) begin
               if (bus.SelA == '0) begin
                  state_d = WAIT_MEM;
                  cnt_d   = cnt_w'(mem_lat - 1);
                  stall_d = 1'b1;
               end else begin
                  acc_d       = sel_data;
                  load_done_d = 1'b1;
               end
            end
         end
         WAIT_MEM: begin
            // Requests arriving here are dropped; upstream holds them until stall falls.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               acc_d       = bus.src_bus[0 +: len_data];
               stall_d     = 1'b0;
               load_done_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            stall_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         stall_q     <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         stall_q     <= stall_d;
         load_done_q <= load_done_d;
      end
   end

   assign bus.acc       = acc_q;
   assign bus.stall     = stall_q;
   assign bus.load_done = load_done_q;
   assign bus.acc_zero  = (acc_q == '0);
   assign bus.acc_neg   = acc_q[len_data-1];
endmodule
`default_nettype wire

// File: tb/tb_acc_load_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_acc_load_unit : directed self-checking bench for acc_load_unit  (rev 1.0)
// ---------------------------------------------------------------------------
module tb_acc_load_unit;
   localparam int len_data = 16;
   localparam int num_src  = 3;
   localparam int len_sel  = 2;
   localparam int mem_lat  = 2;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   acc_load_unit_if #(.len_data(len_data), .num_src(num_src), .len_sel(len_sel)) bus ();

   acc_load_unit #(
      .len_data (len_data),
      .num_src  (num_src),
      .len_sel  (len_sel),
      .mem_lat  (mem_lat)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input logic [15:0] mem, input logic [15:0] opnd, input logic [15:0] alu);
      bus.src_bus = {alu, opnd, mem};
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      bus.WrAcc = 1'b0;
      bus.SelA  = '0;
      set_src(16'h0000, 16'h0000, 16'h0000);
      tick();
      tick();
      check("rst_acc",       32'(bus.acc), 32'h0);
      check("rst_stall",     32'(bus.stall), 32'h0);
      check("rst_done",      32'(bus.load_done), 32'h0);
      check("rst_zero",      32'(bus.acc_zero), 32'h1);
      check("rst_neg",       32'(bus.acc_neg), 32'h0);

      // Operand load
      reset = 1'b0;
      set_src(16'hBEEF, 16'h1234, 16'h0001);
      bus.WrAcc = 1'b1; bus.SelA = 2'd1;
      tick();
      bus.WrAcc = 1'b0;
      check("op_acc",   32'(bus.acc), 32'h1234);
      check("op_done",  32'(bus.load_done), 32'h1);
      check("op_stall", 32'(bus.stall), 32'h0);
      check("op_zero",  32'(bus.acc_zero), 32'h0);
      tick();
      check("op_done_clr", 32'(bus.load_done), 32'h0);
      check("op_hold",     32'(bus.acc), 32'h1234);

      // Memory load with an ignored ALU request during the stall
      bus.WrAcc = 1'b1; bus.SelA = 2'd0;
      tick();
      bus.WrAcc = 1'b0;
      check("mem_stall1", 32'(bus.stall), 32'h1);
      check("mem_acc1",   32'(bus.acc), 32'h1234);
      check("mem_done1",  32'(bus.load_done), 32'h0);
      bus.WrAcc = 1'b1; bus.SelA = 2'd2;
      tick();
      bus.WrAcc = 1'b0;
      check("mem_stall2", 32'(bus.stall), 32'h1);
      check("mem_acc2",   32'(bus.acc), 32'h1234);
      tick();
      check("mem_stall3", 32'(bus.stall), 32'h0);
      check("mem_acc3",   32'(bus.acc), 32'hBEEF);
      check("mem_done3",  32'(bus.load_done), 32'h1);
      check("mem_neg3",   32'(bus.acc_neg), 32'h1);
      tick();
      check("mem_done4",  32'(bus.load_done), 32'h0);
      check("mem_acc4",   32'(bus.acc), 32'hBEEF);

      // Out-of-range select clears acc
      set_src(16'hBEEF, 16'h1234, 16'h00FF);
      bus.WrAcc = 1'b1; bus.SelA = 2'd2;
      tick();
      check("alu_acc", 32'(bus.acc), 32'h00FF);
      bus.SelA = 2'd3;
      tick();
      bus.WrAcc = 1'b0;
      check("oor_acc",  32'(bus.acc), 32'h0000);
      check("oor_zero", 32'(bus.acc_zero), 32'h1);
      check("oor_done", 32'(bus.load_done), 32'h1);

      // Reset aborts a pending memory load
      set_src(16'h7777, 16'h5555, 16'h00FF);
      bus.WrAcc = 1'b1; bus.SelA = 2'd1;
      tick();
      bus.SelA = 2'd0;
      tick();
      bus.WrAcc = 1'b0;
      check("abt_stall", 32'(bus.stall), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abt_acc",   32'(bus.acc), 32'h0);
      check("abt_stall2", 32'(bus.stall), 32'h0);
      check("abt_done",  32'(bus.load_done), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abt_quiet_done", 32'(bus.load_done), 32'h0);
         check("abt_quiet_acc",  32'(bus.acc), 32'h0);
      end

      // ALU 0x8000 then memory load with no idle gap, then back-to-back operand load
      set_src(16'h0042, 16'h00A5, 16'h8000);
      bus.WrAcc = 1'b1; bus.SelA = 2'd2;
      tick();
      check("neg_acc",   32'(bus.acc), 32'h8000);
      check("neg_flag",  32'(bus.acc_neg), 32'h1);
      check("neg_done",  32'(bus.load_done), 32'h1);
      bus.SelA = 2'd0;
      tick();
      bus.WrAcc = 1'b0;
      check("b2b_stall1", 32'(bus.stall), 32'h1);
      check("b2b_acc1",   32'(bus.acc), 32'h8000);
      tick();
      check("b2b_stall2", 32'(bus.stall), 32'h1);
      tick();
      check("b2b_stall3", 32'(bus.stall), 32'h0);
      check("b2b_acc3",   32'(bus.acc), 32'h0042);
      check("b2b_done3",  32'(bus.load_done), 32'h1);
      check("b2b_neg3",   32'(bus.acc_neg), 32'h0);
      bus.WrAcc = 1'b1; bus.SelA = 2'd1;
      tick();
      bus.WrAcc = 1'b0;
      check("b2b_op_acc",  32'(bus.acc), 32'h00A5);
      check("b2b_op_done", 32'(bus.load_done), 32'h1);
      check("b2b_op_stall", 32'(bus.stall), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/acc_load_unit.md
ACC_LOAD_UNIT -- requirements
Module: acc_load_unit

Interface
REQ-001 SHALL have parameter len_data, default 16, meaning width of every data source and of the accumulator.
REQ-002 SHALL have parameter num_src, default 3, meaning number of selectable sources (range 2..2**len_sel).
REQ-003 SHALL have parameter len_sel, default 2, meaning width of SelA.
REQ-004 SHALL have parameter mem_lat, default 2, meaning data-memory read latency in cycles (range 1..15).
REQ-005 SHALL have a single clock and a synchronous, active-high reset, exactly as follows.
REQ-006 clk  input  1  system clock; every register updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 SelA  input  len_sel  source select: code 0 = data memory, code 1 = instruction operand, code 2 = ALU result, codes 3..num_src-1 = extra sources.
REQ-009 WrAcc  input  1  load request, sampled at the rising edge.
REQ-010 src_bus  input  num_src*len_data  packed sources; slice k, bits [k*len_data +: len_data], holds the value for code k.
REQ-011 acc  output  len_data  accumulator register.
REQ-012 stall  output  1  registered; high while a data-memory load is pending.
REQ-013 load_done  output  1  registered; one-cycle pulse in the cycle after acc is written.
REQ-014 acc_zero  output  1  high when acc == 0.
REQ-015 acc_neg  output  1  high when acc[len_data-1] == 1.

Function
REQ-016 SHALL implement an FSM with two states, IDLE and WAIT_MEM, plus a wait counter wide enough to hold mem_lat.
REQ-017 In IDLE, WrAcc=1 with SelA in 1..num_src-1 SHALL load the selected slice into acc at that edge; the state SHALL remain IDLE and load_done SHALL be 1 in the next cycle.
REQ-018 In IDLE, WrAcc=1 with SelA >= num_src SHALL load 0 into acc at that edge and pulse load_done.
REQ-019 In IDLE, WrAcc=1 with SelA=0 SHALL move to WAIT_MEM, set the counter to mem_lat-1 and set stall=1; acc SHALL be unchanged.
REQ-020 In WAIT_MEM with counter > 0, each edge SHALL decrement the counter.
REQ-021 In WAIT_MEM with counter == 0, the edge SHALL load slice 0 into acc, clear stall, pulse load_done and return to IDLE.
REQ-022 stall SHALL therefore be high for exactly mem_lat cycles per memory load.
REQ-023 In WAIT_MEM, WrAcc and SelA SHALL be ignored; a request made while stalled SHALL be lost, and upstream SHALL hold it until stall=0.
REQ-024 In IDLE, WrAcc=0 SHALL hold acc; load_done SHALL be 0 in every cycle that does not follow a write.
REQ-025 A request in the cycle directly after a memory load completes SHALL be accepted normally, giving back-to-back loads with no bubble.
REQ-026 acc_zero and acc_neg SHALL be combinational from acc and valid in the same cycle as acc.
REQ-027 No arithmetic SHALL be performed on data; sources SHALL be passed bit-exact with no extension or truncation.

Reset
REQ-028 reset=1 at an edge SHALL set acc=0, stall=0, load_done=0, the state to IDLE and the counter to 0; acc_zero=1 and acc_neg=0 SHALL follow.
REQ-029 Reset SHALL take priority over WrAcc in all states; reset during WAIT_MEM SHALL abort the pending load, with no later write to acc.

Verification
REQ-030 Reset then WrAcc=1, SelA=1, operand=0x1234 -> next cycle acc=0x1234, load_done=1, stall=0, acc_zero=0.
REQ-031 mem_lat=2, WrAcc=1, SelA=0, mem=0xBEEF -> stall=1 for 2 cycles, then acc=0xBEEF, load_done=1 for one cycle.
REQ-032 During the stall of REQ-031, pulse WrAcc with SelA=2, ALU=0x0001 -> ignored; final acc=0xBEEF.
REQ-033 num_src=3, WrAcc=1, SelA=3 with acc=0x00FF -> acc=0x0000, acc_zero=1, load_done=1.
REQ-034 Start a memory load, assert reset after 1 stall cycle -> acc=0, stall=0, no load_done pulse afterward.
REQ-035 ALU load of 0x8000, then an immediate memory load -> acc_neg=1 after the first load, then stall follows with no idle cycle between.
